// File: rtl/instruction_loader.sv
// instruction_loader
//
// Debug/program loader between a UART receiver and the pipeline's instruction
// memory write port and halt input. Single-byte commands in IDLE:
//   'L' (0x4C) + count N + 4*N bytes (MSB first) : load N words
//   'R' (0x52) : free-run until 'H' (0x48)
//   'S' (0x53) : release halt for exactly one cycle
// Anything else in IDLE pulses o_error.
//
// Ports:
//   i_clk, i_reset              clock, synchronous active-high reset
//   i_rx_valid, i_rx_data       one-cycle byte strobe and data, no backpressure
//   o_halt                      1 freezes the pipeline
//   o_write_instruction_flag    one-cycle instruction-memory write strobe
//   o_instruction_to_write      assembled word (held until next write)
//   o_address_to_write_inst     byte address of that word
//   o_busy                      high outside IDLE
//   o_error                     one-cycle error pulse
//
// Optional: define LOADER_TIMEOUT_EN to abort a load after TIMEOUT_CYCLES
// consecutive cycles without a byte.

module instruction_loader #(
    parameter int unsigned MAX_WORDS      = 64,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    output logic        o_halt,
    output logic        o_write_instruction_flag,
    output logic [31:0] o_instruction_to_write,
    output logic [31:0] o_address_to_write_inst,
    output logic        o_busy,
    output logic        o_error
);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StLoadCnt  = 3'd1;
    localparam logic [2:0] StLoadByte = 3'd2;
    localparam logic [2:0] StRun      = 3'd3;
    localparam logic [2:0] StStep     = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  idx_q, idx_d;
    logic [1:0]  bidx_q, bidx_d;
    logic [31:0] shift_q, shift_d;
    logic        halt_q, halt_d;
    logic        wr_q, wr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] addr_q, addr_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
`ifdef LOADER_TIMEOUT_EN
    logic [31:0] to_q, to_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        bidx_d  = bidx_q;
        shift_d = shift_q;
        wr_d    = 1'b0;
        err_d   = 1'b0;
        data_d  = data_q;
        addr_d  = addr_q;

        case (state_q)
            StIdle: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        8'h4C:   state_d = StLoadCnt;
                        8'h52:   state_d = StRun;
                        8'h53:   state_d = StStep;
                        default: err_d   = 1'b1;
                    endcase
                end
            end
            StLoadCnt: begin
                if (i_rx_valid) begin
                    if (i_rx_data == 8'd0) begin
                        state_d = StIdle;
                    end else if ({24'd0, i_rx_data} > MAX_WORDS) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        cnt_d   = i_rx_data;
                        idx_d   = 8'd0;
                        bidx_d  = 2'd0;
                        shift_d = 32'd0;
                        state_d = StLoadByte;
                    end
                end
            end
            StLoadByte: begin
                if (i_rx_valid) begin
                    case (bidx_q)
                        2'd0:    shift_d[31:24] = i_rx_data;
                        2'd1:    shift_d[23:16] = i_rx_data;
                        2'd2:    shift_d[15:8]  = i_rx_data;
                        default: shift_d[7:0]   = i_rx_data;
                    endcase
                    // Two-bit byte index wraps back to 0 after the 4th byte.
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        // Last byte bypasses the shift register so the word
                        // is registered in the same cycle it completes.
                        data_d = {shift_q[31:8], i_rx_data};
                        addr_d = BASE_ADDR + {22'd0, idx_q, 2'b00};
                        wr_d   = 1'b1;
                        idx_d  = idx_q + 8'd1;
                        if (idx_d == cnt_q) begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            StRun: begin
                if (i_rx_valid && i_rx_data == 8'h48) begin
                    state_d = StIdle;
                end
            end
            StStep: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef LOADER_TIMEOUT_EN
        to_d = 32'd0;
        if (state_q == StLoadCnt || state_q == StLoadByte) begin
            if (!i_rx_valid) begin
                if (to_q == TIMEOUT_CYCLES - 1) begin
                    // Abort: partial word is simply dropped, no strobe.
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    to_d = to_q + 32'd1;
                end
            end
        end
`endif

        // Outputs are registered from the next state so they line up with it.
        halt_d = !(state_d == StRun || state_d == StStep);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            idx_q   <= 8'd0;
            bidx_q  <= 2'd0;
            shift_q <= 32'd0;
            halt_q  <= 1'b1;
            wr_q    <= 1'b0;
            data_q  <= 32'd0;
            addr_q  <= 32'd0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            to_q    <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            bidx_q  <= bidx_d;
            shift_q <= shift_d;
            halt_q  <= halt_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
`ifdef LOADER_TIMEOUT_EN
            to_q    <= to_d;
`endif
        end
    end

    assign o_halt                   = halt_q;
    assign o_write_instruction_flag = wr_q;
    assign o_instruction_to_write   = data_q;
    assign o_address_to_write_inst  = addr_q;
    assign o_busy                   = busy_q;
    assign o_error                  = err_q;

endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader
//
// Self-checking bench for instruction_loader. One process drives bytes and
// samples outputs 1 time unit after each rising edge, recording writes, error
// pulse cycles and halt-low cycles. Expected words/addresses come from a
// simple list model: word i of a load lands at BASE_ADDR + 4*i.
// The timeout scenario is exercised when LOADER_TIMEOUT_EN is defined.

module tb_instruction_loader;

    localparam int unsigned MaxWords = 64;
    localparam logic [31:0] BaseAddr = 32'h0;
    localparam int unsigned ToCycles = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        v;
    logic [7:0]  d;
    logic        halt;
    logic        wr;
    logic [31:0] data;
    logic [31:0] addr;
    logic        busy;
    logic        err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic [31:0] exp_w[$];
    int          err_pulses;
    int          halt_low;

    always #5 clk = ~clk;

    instruction_loader #(
        .MAX_WORDS      (MaxWords),
        .BASE_ADDR      (BaseAddr),
        .TIMEOUT_CYCLES (ToCycles)
    ) dut (
        .i_clk                    (clk),
        .i_reset                  (rst),
        .i_rx_valid               (v),
        .i_rx_data                (d),
        .o_halt                   (halt),
        .o_write_instruction_flag (wr),
        .o_instruction_to_write   (data),
        .o_address_to_write_inst  (addr),
        .o_busy                   (busy),
        .o_error                  (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: present (vv, dd), then sample outputs just after the edge.
    task automatic cyc(input logic vv, input logic [7:0] dd);
        v = vv;
        d = dd;
        @(posedge clk);
        #1;
        v = 1'b0;
        if (wr) begin
            obs_addr.push_back(addr);
            obs_data.push_back(data);
        end
        if (err) err_pulses++;
        if (!halt) halt_low++;
    endtask

    task automatic clear();
        obs_addr.delete();
        obs_data.delete();
        err_pulses = 0;
        halt_low   = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
    endtask

    // Send a word MSB first, optionally with idle gaps between bytes.
    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int k = 0; k < 4; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) cyc(1'b0, 8'($urandom));
            cyc(1'b1, w[31-8*k -: 8]);
        end
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_nwr"}, obs_data.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < obs_data.size(); i++) begin
            check({tag, "_data"}, obs_data[i], exp_w[i]);
            check({tag, "_addr"}, obs_addr[i], BaseAddr + 32'(4 * i));
        end
    endtask

    task automatic load_random(input int n);
        logic [31:0] w;
        clear();
        exp_w.delete();
        cyc(1'b1, 8'h4C);
        cyc(1'b1, 8'(n));
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            exp_w.push_back(w);
            send_word(w, 1'b1);
        end
        check("rand_busy_end", busy, 1'b0);
        idle(2);
        compare_writes("rand");
        check("rand_halt_low", halt_low, 0);
        check("rand_err", err_pulses, 0);
        if (n > 0) check("rand_hold", data, exp_w[n-1]);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        logic [7:0] b;
        rst = 1'b1;
        v   = 1'b0;
        d   = 8'h00;
        clear();

        // Reset
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        check("rst_halt", halt, 1'b1);
        check("rst_wr",   wr,   1'b0);
        check("rst_data", data, 32'h0);
        check("rst_addr", addr, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_err",  err,  1'b0);
        rst = 1'b0;

        // Directed two-word load
        clear();
        exp_w.delete();
        exp_w.push_back(32'h20080005);
        exp_w.push_back(32'h8C090004);
        cyc(1'b1, 8'h4C);
        check("load_busy_cnt", busy, 1'b1);
        cyc(1'b1, 8'h02);
        send_word(32'h20080005, 1'b0);
        check("load_busy_mid", busy, 1'b1);
        send_word(32'h8C090004, 1'b0);
        check("load_busy_end", busy, 1'b0);
        idle(2);
        compare_writes("two");
        check("two_halt_low", halt_low, 0);
        check("two_wr_idle", wr, 1'b0);

        // Randomized loads, including the maximum count
        for (int r = 0; r < 4; r++) load_random($urandom_range(1, 8));
        load_random(MaxWords);

        // Run / halt with random ignored bytes
        clear();
        cyc(1'b1, 8'h52);
        check("run_halt", halt, 1'b0);
        check("run_busy", busy, 1'b1);
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            if (b == 8'h48) b = 8'h49;
            cyc($urandom_range(0, 1) == 1, b);
        end
        check("run_still", halt, 1'b0);
        cyc(1'b1, 8'h48);
        check("halt_after_h", halt, 1'b1);
        check("halt_busy", busy, 1'b0);
        check("run_err", err_pulses, 0);

        // Single step; an 'R' during STEP must be ignored
        clear();
        cyc(1'b1, 8'h53);
        check("step_halt", halt, 1'b0);
        cyc(1'b1, 8'h52);
        check("step_back", halt, 1'b1);
        idle(3);
        check("step_low_cycles", halt_low, 1);
        check("step_busy", busy, 1'b0);

        // Bad command
        clear();
        cyc(1'b1, 8'h7A);
        check("bad_err_now", err, 1'b1);
        idle(2);
        check("bad_err_cnt", err_pulses, 1);
        check("bad_busy", busy, 1'b0);
        clear();
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            if (b == 8'h4C || b == 8'h52 || b == 8'h53) b = 8'h00;
            cyc(1'b1, b);
        end
        idle(1);
        check("bad_rand_cnt", err_pulses, 5);
        check("bad_rand_busy", busy, 1'b0);

        // Zero count
        clear();
        cyc(1'b1, 8'h4C);
        cyc(1'b1, 8'h00);
        check("zero_busy", busy, 1'b0);
        idle(2);
        check("zero_nwr", obs_data.size(), 0);
        check("zero_err", err_pulses, 0);

        // Oversize counts
        clear();
        cyc(1'b1, 8'h4C);
        cyc(1'b1, 8'h41);
        check("over_err", err, 1'b1);
        check("over_busy", busy, 1'b0);
        cyc(1'b1, 8'h4C);
        cyc(1'b1, 8'hFF);
        idle(2);
        check("over_err_cnt", err_pulses, 2);
        check("over_nwr", obs_data.size(), 0);

        // Last byte followed immediately by a command
        clear();
        exp_w.delete();
        exp_w.push_back($urandom);
        cyc(1'b1, 8'h4C);
        cyc(1'b1, 8'h01);
        send_word(exp_w[0], 1'b0);
        cyc(1'b1, 8'h52);
        check("b2b_halt", halt, 1'b0);
        compare_writes("b2b");
        cyc(1'b1, 8'h48);
        check("b2b_halted", halt, 1'b1);

        // Reset mid-load
        clear();
        cyc(1'b1, 8'h4C);
        cyc(1'b1, 8'h01);
        cyc(1'b1, 8'hAA);
        cyc(1'b1, 8'hBB);
        rst = 1'b1;
        cyc(1'b1, 8'hCC);
        rst = 1'b0;
        check("mid_busy", busy, 1'b0);
        check("mid_halt", halt, 1'b1);
        check("mid_data", data, 32'h0);
        idle(2);
        check("mid_nwr", obs_data.size(), 0);
        load_random(1);

`ifdef LOADER_TIMEOUT_EN
        clear();
        cyc(1'b1, 8'h4C);
        cyc(1'b1, 8'h01);
        cyc(1'b1, 8'h11);
        idle(ToCycles - 1);
        check("to_busy_before", busy, 1'b1);
        check("to_err_before", err_pulses, 0);
        idle(1);
        check("to_err", err, 1'b1);
        check("to_busy", busy, 1'b0);
        idle(2);
        check("to_err_cnt", err_pulses, 1);
        check("to_nwr", obs_data.size(), 0);
`else
        clear();
        cyc(1'b1, 8'h4C);
        cyc(1'b1, 8'h01);
        cyc(1'b1, 8'h11);
        idle(3 * ToCycles);
        check("nto_busy", busy, 1'b1);
        check("nto_err", err_pulses, 0);
        rst = 1'b1;
        cyc(1'b0, 8'h00);
        rst = 1'b0;
        check("nto_reset_busy", busy, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Debug/program loader that drives the pipeline's instruction-memory write port and halt control. Consumes a byte stream from a UART receiver, decodes single-byte commands, assembles 32-bit instruction words, and issues one write per word at consecutive byte addresses. It also gates execution: free-run, single-step, or halt. Sits between the UART RX block and the `pipeline` top-level inputs `i_halt`, `i_write_instruction_flag`, `i_instruction_to_write` and `i_address_to_write_inst`.

## Interface
- `MAX_WORDS`, 64: maximum word count accepted by a load command (1..255).
- `BASE_ADDR`, 32'h0: byte address written for word 0.
- `TIMEOUT_CYCLES`, 100000: idle-byte watchdog limit; used only with `LOADER_TIMEOUT_EN`.

- `i_clk` in 1: single clock, rising edge.
- `i_reset` in 1: synchronous, active-high reset.
- `i_rx_valid` in 1: one-cycle strobe; `i_rx_data` is valid in that cycle. No backpressure.
- `i_rx_data` in 8: received byte.
- `o_halt` out 1: to pipeline `i_halt`; 1 freezes the pipeline.
- `o_write_instruction_flag` out 1: one-cycle instruction-memory write strobe.
- `o_instruction_to_write` out 32: assembled instruction word.
- `o_address_to_write_inst` out 32: byte address of the word.
- `o_busy` out 1: high in every state except IDLE.
- `o_error` out 1: one-cycle error pulse.

## Operation
- States: IDLE, LOAD_CNT, LOAD_BYTE, RUN, STEP.
- In the state descriptions below, a byte is a cycle with `i_rx_valid`=1. Cycles with `i_rx_valid`=0 leave the state unchanged.
- **IDLE** (`o_halt`=1):
  - 0x4C 'L' moves to LOAD_CNT.
  - 0x52 'R' moves to RUN.
  - 0x53 'S' moves to STEP.
  - Any other byte pulses `o_error` and stays in IDLE.
- **LOAD_CNT**: the byte is the word count N.
  - N=0 returns to IDLE with no write and no error.
  - N>`MAX_WORDS` pulses `o_error` and returns to IDLE.
  - Otherwise latch N, clear the word index and byte index, and move to LOAD_BYTE.
- **LOAD_BYTE**: bytes arrive MSB first. Byte k (0..3) fills bits [31-8k -: 8] of the shift register.
  - On byte 3: `o_instruction_to_write` and `o_address_to_write_inst` register the word and `BASE_ADDR + 4*index`, `o_write_instruction_flag` asserts, and the word index increments.
  - If the incremented index equals N, go to IDLE. Otherwise stay in LOAD_BYTE with the byte index back at 0.
- **RUN** (`o_halt`=0):
  - 0x48 'H' returns to IDLE.
  - All other bytes are ignored.
- **STEP**: `o_halt`=0 for exactly one cycle, then IDLE unconditionally. Bytes arriving during STEP are ignored.
- `o_halt` stays 1 throughout load. Memory is written only while the pipeline is frozen.
- Address arithmetic is 32-bit unsigned and wraps modulo 2^32. The word index is 8 bits.

## Timing
- Reset values:
  - `o_halt`=1; `o_write_instruction_flag`=0; `o_instruction_to_write`=0; `o_address_to_write_inst`=0; `o_busy`=0; `o_error`=0.
  - State is IDLE; all counters are 0.
- All outputs are registered.
- Latencies, with byte accepted in cycle t:
  - The state change is visible at t+1.
  - The write strobe, data and address appear at t+1 for the 4th byte and are high for exactly one cycle. Data and address hold until the next write or reset.
  - `o_error` pulses at t+1 for exactly one cycle.
  - After 'R', `o_halt` falls at t+1. After 'H', it rises at t+1.
  - After 'S', `o_halt`=0 only in cycle t+1.
- Back-to-back bytes in consecutive cycles are supported with no loss, including the 4th byte of the last word followed immediately by a command byte.
- `i_reset` mid-load aborts immediately. Words already written remain in memory. The partial word is discarded and no strobe is issued.

## Configuration
- `LOADER_TIMEOUT_EN` defined:
  - In LOAD_CNT and LOAD_BYTE, a counter clears on each accepted byte and increments otherwise.
  - On reaching `TIMEOUT_CYCLES`, it pulses `o_error`, discards the partial word (no strobe) and returns to IDLE.
- `LOADER_TIMEOUT_EN` undefined: no counter; the loader waits indefinitely for bytes.

## Test plan
- **Reset:** hold `i_reset` 2 cycles -> all outputs at their reset values, `o_halt`=1.
- **Two-word load:** bytes 4C,02, 20,08,00,05, 8C,09,00,04 -> two strobes.
  - Write 32'h20080005 @0.
  - Write 32'h8C090004 @4.
  - `o_busy` falls after the last byte; `o_halt`=1 throughout.
- **Run/halt and step:**
  - 52 -> `o_halt`=0 until 48; 48 -> `o_halt`=1 next cycle.
  - 53 -> exactly one cycle of `o_halt`=0.
- **Bad command, zero count, oversize count:**
  - 7A -> one `o_error` pulse, still IDLE.
  - 4C,00 -> IDLE with no strobe and no error.
  - 4C,41 with `MAX_WORDS`=64 -> `o_error`, IDLE.
- **Reset mid-load:** 4C,01,AA,BB, then `i_reset` -> no strobe, state IDLE. A fresh load afterwards writes @0.
- **Timeout:** with `LOADER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, send 4C,01,11, then idle 16 cycles -> `o_error` pulse, no strobe, IDLE.
